mul_accum_ctrl: RTL and testbench

- Control and accumulate stage for the repeated-addition multiplier; sits directly upstream of the 16-bit product register.
- Latches multiplicand A and multiplier B from a shared data bus, then forms the next product value (P + A).
- Drives the product register's clear and load strobes once per addition, counting B down to zero.
- Signals completion to the system with a busy/done handshake.

---
 rtl/mul_accum_ctrl.sv | 96 +++++++++
 tb/tb_mul_accum_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mul_accum_ctrl.sv
// Control/accumulate stage of the repeated-addition multiplier: latches A and B off a shared bus
// and strobes the product register. Define MUL_OVF_DET_EN to build the sticky carry-out flag.
module mul_accum_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] p_q,
    output logic [WIDTH-1:0] p_d,
    output logic             ld_p,
    output logic             clr_p,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StAccum, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_cnt;
    logic             b_zero;

    assign b_zero = (b_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_reg   <= '0;
            b_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StLoadA) a_reg <= data_in;
            if (state_q == StLoadB) b_cnt <= data_in;
            else if (state_q == StAccum && !b_zero) b_cnt <= b_cnt - 1'b1;
        end
    end

    // Moore decode only: strobes follow the async-reset state, so they drop with rst.
    always_comb begin
        state_d = state_q;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoadA;
            end
            StLoadA: begin
                busy    = 1'b1;
                state_d = StLoadB;
            end
            StLoadB: begin
                busy    = 1'b1;
                clr_p   = 1'b1;
                state_d = StAccum;
            end
            StAccum: begin
                busy = 1'b1;
                if (b_zero) state_d = StDone;
                else        ld_p    = 1'b1;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MUL_OVF_DET_EN
    logic [WIDTH:0] sum;
    logic           ovf_q;

    assign sum = {1'b0, p_q} + {1'b0, a_reg};
    assign p_d = sum[WIDTH-1:0];
    assign ovf = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StLoadA) begin
            ovf_q <= 1'b0;
        end else if (ld_p && sum[WIDTH]) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign p_d = p_q + a_reg;
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mul_accum_ctrl.sv
// Scoreboard bench for mul_accum_ctrl with a behavioural product register (clr beats ld).
module tb_mul_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic [15:0] p_q;
    logic [15:0] p_d;
    logic        ld_p, clr_p, busy, done, ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] p;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    mul_accum_ctrl #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .p_q     (p_q),
        .p_d     (p_d),
        .ld_p    (ld_p),
        .clr_p   (clr_p),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Product register model: never reset, sync clear has priority over load.
    initial p_q = 16'h1234;
    always @(posedge clk) begin
        if (clr_p)     p_q <= 16'h0000;
        else if (ld_p) p_q <= p_d;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit ovf_exp(input logic [15:0] a, input int n);
`ifdef MUL_OVF_DET_EN
        return (longint'(a) * longint'(n)) > 64'd65535;
`else
        return 1'b0;
`endif
    endfunction

    // Result checker: every done pulse must match the oldest pending operation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_p", p_q, e.p);
                check("result_ovf", ovf, e.ovf);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Assumes the DUT will be in IDLE at the next negedge.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input bit poke, input bit keep);
        exp_t        e;
        logic [31:0] prod;
        int          n;
        bit          seen;
        @(negedge clk);
        check("idle_busy", busy, 0);
        start   = 1'b1;
        data_in = 16'hDEAD;
        prod    = 32'(a) * 32'(b);
        e.p     = prod[15:0];
        e.ovf   = ovf_exp(a, int'(b));
        e.cyc   = cyc + int'(b) + 4;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        data_in = a;
        check("loada_busy", busy, 1);
        check("loada_clr", clr_p, 0);
        @(negedge clk);
        data_in = b;
        check("loadb_clr", clr_p, 1);
        check("loadb_ldp", ld_p, 0);
        check("loadb_ovf", ovf, 0);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < int'(b) + 8 && !seen; i++) begin
            @(negedge clk);
            data_in = 16'($urandom);
            start   = poke && (i == 0);
            check("accum_ovf", ovf, ovf_exp(a, n));
            if (done) begin
                seen = 1'b1;
                check("done_ldp", ld_p, 0);
                check("done_busy", busy, 0);
                if (keep) start = 1'b1;
            end else if (ld_p) begin
                check("accum_p_d", p_d, 16'(p_q + a));
                n++;
            end
        end
        check("done_seen", seen, 1);
        check("ld_count", n, int'(b));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ldp", ld_p, 0);
        check("rst_clr", clr_p, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_p_d", p_d, p_q);
        rst = 1'b0;

        op(16'd5, 16'd3, 1'b0, 1'b0);
        op(16'd9, 16'd0, 1'b0, 1'b0);
        op(16'd0, 16'd4, 1'b0, 1'b0);
        op(16'hFFFF, 16'd1, 1'b0, 1'b0);
        op(16'd7, 16'd2, 1'b1, 1'b1);
        op(16'd4, 16'd5, 1'b0, 1'b0);

        // Reset in the middle of ACCUM for A=3, B=10.
        @(negedge clk);
        check("mid_idle_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd3;
        @(negedge clk);
        data_in = 16'd10;
        repeat (5) @(negedge clk);
        check("mid_ldp_before", ld_p, 1);
        check("mid_p_before", p_q, 16'd12);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ldp", ld_p, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_clr", clr_p, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_state", 32'(dut.state_q), 0);
        check("mid_rst_p_d", p_d, p_q);
        @(negedge clk);
        rst = 1'b0;

        op(16'd2, 16'd6, 1'b0, 1'b0);
        op(16'h8000, 16'd3, 1'b0, 1'b0);
        op(16'd1, 16'd1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so a stuck DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
